// File: rtl/mul_cmp_sched_if.sv
// Bundle of signals between multiply clients, the shared compressor tree and the scheduler.
// The scheduler takes the slave side; the clients plus compressor take the master side.
interface mul_cmp_sched_if #(
    parameter int W    = 9,
    parameter int NREQ = 3
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W*W-1:0]    cmp_pp;
    logic [2*W-1:0]    cmp_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [2*W-1:0]    rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, cmp_sum,
        input  req_ready, cmp_pp, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, cmp_sum,
        output req_ready, cmp_pp, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/mul_cmp_sched.sv
// Round-robin scheduler sharing one WxW partial-product compressor among NREQ clients.
// Credits cover both the ops still travelling through the compressor and the buffered
// results, so the compressor path never has to stall.
module mul_cmp_sched #(
    parameter int W         = 9,
    parameter int NREQ      = 3,
    parameter int CMP_LAT   = 0,
    parameter int RSP_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    mul_cmp_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int PW = 2 * W;

    // Number of partial-product bits in column k of the compressor.
    function automatic int col_cnt(int k);
        return (k < W) ? k + 1 : 2 * W - 1 - k;
    endfunction

    // Bit offset of column k inside the column-packed cmp_pp vector.
    function automatic int col_off(int k);
        int s;
        s = 0;
        for (int c = 0; c < k; c++) s += col_cnt(c);
        return s;
    endfunction

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   grant_id;
    logic            grant_any;
    logic            credit_ok;
    logic            accept;
    logic [NREQ-1:0] grant_vec;
    logic [CW:0]     credit_sum;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;

    logic            iss_valid;
    logic [IW-1:0]   iss_id;
    logic [W-1:0]    iss_a;
    logic [W-1:0]    iss_b;
    logic [W*W-1:0]  pp;

    logic            tag_valid;
    logic [IW-1:0]   tag_id;

    logic [PW-1:0]   mem_prod [RSP_DEPTH];
    logic [IW-1:0]   mem_id   [RSP_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [IW-1:0]   last_id;
    logic [PW-1:0]   last_prod;
    logic            push;
    logic            pop;
    logic            fifo_nonempty;

    assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok  = credit_sum < (CW+1)'(RSP_DEPTH);
    assign accept     = grant_any & credit_ok & ~rst;

    // Search for the first valid requester starting at the round-robin pointer.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IW'(idx);
            end
        end
    end

    // One-hot ready toward the winning requester, suppressed while out of credit or in reset.
    always_comb begin
        grant_vec = '0;
        if (accept) grant_vec[grant_id] = 1'b1;
    end

    assign bus.req_ready = grant_vec;

    // Round-robin pointer moves past the requester that was just accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Issue register: captures the accepted operands for exactly one cycle of valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
        end else begin
            iss_valid <= accept;
            if (accept) begin
                iss_id <= grant_id;
                iss_a  <= bus.req_a[int'(grant_id)*W +: W];
                iss_b  <= bus.req_b[int'(grant_id)*W +: W];
            end
        end
    end

    // Column-packed partial products, lowest weight first; zero while the issue slot is empty.
    for (genvar k = 0; k < 2*W-1; k++) begin : g_col
        for (genvar j = 0; j < col_cnt(k); j++) begin : g_bit
            localparam int I = (((k - W + 1) > 0) ? (k - W + 1) : 0) + j;
            assign pp[col_off(k) + j] = iss_valid & iss_a[I] & iss_b[k - I];
        end
    end

    assign bus.cmp_pp = pp;

    if (CMP_LAT == 0) begin : g_nolat
        assign tag_valid = iss_valid;
        assign tag_id    = iss_id;
    end else begin : g_lat
        logic [CMP_LAT-1:0] pv;
        logic [IW-1:0]      pid [CMP_LAT];

        // Tag pipe shadows the compressor registers so the id lines up with cmp_sum.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv <= '0;
                for (int s = 0; s < CMP_LAT; s++) pid[s] <= '0;
            end else begin
                pv[0]  <= iss_valid;
                pid[0] <= iss_id;
                for (int s = 1; s < CMP_LAT; s++) begin
                    pv[s]  <= pv[s-1];
                    pid[s] <= pid[s-1];
                end
            end
        end

        assign tag_valid = pv[CMP_LAT-1];
        assign tag_id    = pid[CMP_LAT-1];
    end

    assign fifo_nonempty = fifo_count != '0;
    assign push          = tag_valid;
    assign pop           = fifo_nonempty & bus.rsp_ready;

    // In-flight counter: ops between accept and their FIFO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (accept && !push) begin
            inflight <= inflight + CW'(1);
        end else if (!accept && push) begin
            inflight <= inflight - CW'(1);
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push && pop) fifo_count <= fifo_count - CW'(1);
        end
    end

    // Storage array needs no reset; only slots below the count are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_prod[wr_ptr] <= bus.cmp_sum;
            mem_id[wr_ptr]   <= tag_id;
        end
    end

    // Remember the last popped entry so the response fields hold while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id   <= '0;
            last_prod <= '0;
        end else if (pop) begin
            last_id   <= mem_id[rd_ptr];
            last_prod <= mem_prod[rd_ptr];
        end
    end

    assign bus.rsp_valid = fifo_nonempty;
    assign bus.rsp_id    = fifo_nonempty ? mem_id[rd_ptr]   : last_id;
    assign bus.rsp_prod  = fifo_nonempty ? mem_prod[rd_ptr] : last_prod;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_mul_cmp_sched.sv
// Bench for mul_cmp_sched: two instances (combinational and 2-stage compressor) share
// one random/directed stimulus stream and are each checked against an outstanding-op
// queue model built from the accept/credit/ordering rules.
module tb_mul_cmp_sched;
    localparam int W     = 9;
    localparam int NREQ  = 3;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [2:0]  vv    = '0;
    logic [26:0] va    = '0;
    logic [26:0] vb    = '0;
    logic        rr_in = 1'b0;

    int checks = 0;
    int errors = 0;

    mul_cmp_sched_if #(.W(W), .NREQ(NREQ)) if0 ();
    mul_cmp_sched_if #(.W(W), .NREQ(NREQ)) if2 ();

    mul_cmp_sched #(.W(W), .NREQ(NREQ), .CMP_LAT(0), .RSP_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    mul_cmp_sched #(.W(W), .NREQ(NREQ), .CMP_LAT(2), .RSP_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    always #5 clk = ~clk;

    // Compressor model: add up every bit of each column at that column's weight.
    function automatic logic [17:0] compress(logic [80:0] p);
        int pos;
        int n;
        logic [17:0] s;
        pos = 0;
        s   = '0;
        for (int k = 0; k < 17; k++) begin
            n = (k < 9) ? k + 1 : 17 - k;
            for (int j = 0; j < n; j++) begin
                s   = s + ({17'b0, p[pos]} << k);
                pos = pos + 1;
            end
        end
        return s;
    endfunction

    logic [17:0] c2_r1;
    logic [17:0] c2_r2;

    assign if0.req_valid = vv;
    assign if0.req_a     = va;
    assign if0.req_b     = vb;
    assign if0.rsp_ready = rr_in;
    assign if0.cmp_sum   = compress(if0.cmp_pp);
    assign if2.req_valid = vv;
    assign if2.req_a     = va;
    assign if2.req_b     = vb;
    assign if2.rsp_ready = rr_in;
    assign if2.cmp_sum   = c2_r2;

    // Two register stages in front of the second instance's compressor result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c2_r1 <= '0;
            c2_r2 <= '0;
        end else begin
            c2_r1 <= compress(if2.cmp_pp);
            c2_r2 <= c2_r1;
        end
    end

    logic [2:0]  obs_rr   [2];
    logic        obs_rv   [2];
    logic [1:0]  obs_id   [2];
    logic [17:0] obs_prod [2];
    logic [80:0] obs_pp   [2];

    assign obs_rr[0]   = if0.req_ready;
    assign obs_rr[1]   = if2.req_ready;
    assign obs_rv[0]   = if0.rsp_valid;
    assign obs_rv[1]   = if2.rsp_valid;
    assign obs_id[0]   = if0.rsp_id;
    assign obs_id[1]   = if2.rsp_id;
    assign obs_prod[0] = if0.rsp_prod;
    assign obs_prod[1] = if2.rsp_prod;
    assign obs_pp[0]   = if0.cmp_pp;
    assign obs_pp[1]   = if2.cmp_pp;

    int m_cyc;
    int m_ptr     [2];
    int m_head    [2];
    int m_tail    [2];
    int q_id      [2][64];
    int q_prod    [2][64];
    int q_rdy     [2][64];
    int last_id   [2];
    int last_prod [2];
    int pend_g    [2];
    int pend_pop  [2];
    int obs_acc   [2];

    task automatic chk(string tag, int d, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cyc = 0;
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]     = 0;
            m_head[d]    = 0;
            m_tail[d]    = 0;
            last_id[d]   = 0;
            last_prod[d] = 0;
            pend_g[d]    = -1;
            pend_pop[d]  = 0;
        end
    endtask

    // Compare live outputs with the model and note which handshakes the model expects.
    task automatic check_output();
        int outstanding;
        int g;
        int idx;
        int h;
        logic [2:0] eg;
        logic erv;
        for (int d = 0; d < 2; d++) begin
            outstanding = m_tail[d] - m_head[d];
            h  = m_head[d] % 64;
            g  = -1;
            eg = '0;
            if (outstanding < DEPTH) begin
                for (int off = 0; off < NREQ; off++) begin
                    idx = (m_ptr[d] + off) % NREQ;
                    if (g < 0 && vv[idx]) g = idx;
                end
            end
            if (g >= 0) eg[g] = 1'b1;
            chk("req_ready", d, 128'(obs_rr[d]), 128'(eg));
            if ((obs_rr[d] & vv) != 3'b000) obs_acc[d]++;
            erv = (outstanding > 0) && (q_rdy[d][h] <= m_cyc);
            chk("rsp_valid", d, 128'(obs_rv[d]), 128'(erv));
            if (erv) begin
                chk("rsp_id", d, 128'(obs_id[d]), 128'(q_id[d][h]));
                chk("rsp_prod", d, 128'(obs_prod[d]), 128'(q_prod[d][h]));
            end else begin
                chk("rsp_id_hold", d, 128'(obs_id[d]), 128'(last_id[d]));
                chk("rsp_prod_hold", d, 128'(obs_prod[d]), 128'(last_prod[d]));
            end
            pend_g[d]   = g;
            pend_pop[d] = (erv && rr_in) ? 1 : 0;
        end
    endtask

    // Advance the model across one rising edge.
    task automatic update_model();
        int t;
        int g;
        m_cyc++;
        for (int d = 0; d < 2; d++) begin
            if (pend_pop[d] != 0) begin
                t            = m_head[d] % 64;
                last_id[d]   = q_id[d][t];
                last_prod[d] = q_prod[d][t];
                m_head[d]++;
            end
            g = pend_g[d];
            if (g >= 0) begin
                t            = m_tail[d] % 64;
                q_id[d][t]   = g;
                q_prod[d][t] = int'(va[g*W +: W]) * int'(vb[g*W +: W]);
                q_rdy[d][t]  = m_cyc + 1 + ((d == 0) ? 0 : 2);
                m_tail[d]++;
                m_ptr[d]     = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] v, input logic [26:0] a,
                                  input logic [26:0] b, input logic r);
        vv    = v;
        va    = a;
        vb    = b;
        rr_in = r;
        @(negedge clk);
        check_output();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic run_cycles(input int n, input logic [2:0] v, input logic r);
        for (int i = 0; i < n; i++) apply_stimulus(v, 27'($urandom), 27'($urandom), r);
    endtask

    task automatic reset_dut();
        vv  = '0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_rsp_valid", d, 128'(obs_rv[d]), 128'(0));
            chk("reset_req_ready", d, 128'(obs_rr[d]), 128'(0));
            chk("reset_rsp_id", d, 128'(obs_id[d]), 128'(0));
            chk("reset_rsp_prod", d, 128'(obs_prod[d]), 128'(0));
            chk("reset_cmp_pp", d, 128'(obs_pp[d]), 128'(0));
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int a2;
        logic [127:0] exp_pp;

        for (int d = 0; d < 2; d++) obs_acc[d] = 0;
        model_clear();
        #2;
        reset_dut();

        $display("[TB] single op from requester 1, 511 x 511");
        apply_stimulus(3'b010, 27'(511) << 9, 27'(511) << 9, 1'b1);
        apply_stimulus(3'b000, '0, '0, 1'b1);
        chk("single_valid", 0, 128'(if0.rsp_valid), 128'(1));
        chk("single_id", 0, 128'(if0.rsp_id), 128'(1));
        chk("single_prod", 0, 128'(if0.rsp_prod), 128'(18'h3FC01));
        run_cycles(5, 3'b000, 1'b1);
        chk("idle_cmp_pp", 0, 128'(if0.cmp_pp), 128'(0));

        $display("[TB] partial-product packing corners");
        apply_stimulus(3'b001, 27'd1, 27'd1, 1'b1);
        chk("pp_lsb", 0, 128'(if0.cmp_pp), 128'(1));
        chk("pp_lsb", 1, 128'(if2.cmp_pp), 128'(1));
        apply_stimulus(3'b000, '0, '0, 1'b1);
        apply_stimulus(3'b100, 27'(9'h100) << 18, 27'(9'h100) << 18, 1'b1);
        exp_pp = 128'(1) << 80;
        chk("pp_msb", 0, 128'(if0.cmp_pp), exp_pp);
        chk("pp_msb", 1, 128'(if2.cmp_pp), exp_pp);
        apply_stimulus(3'b001, 27'd0, 27'($urandom), 1'b1);
        run_cycles(8, 3'b000, 1'b1);

        $display("[TB] fairness with all requesters valid");
        a0 = obs_acc[0];
        run_cycles(12, 3'b111, 1'b1);
        chk("no_bubble_accepts", 0, 128'(obs_acc[0] - a0), 128'(12));
        run_cycles(10, 3'b000, 1'b1);

        $display("[TB] backpressure against full credit");
        a0 = obs_acc[0];
        a2 = obs_acc[1];
        run_cycles(8, 3'b111, 1'b0);
        chk("bp_accepts", 0, 128'(obs_acc[0] - a0), 128'(DEPTH));
        chk("bp_accepts", 1, 128'(obs_acc[1] - a2), 128'(DEPTH));
        a0 = obs_acc[0];
        a2 = obs_acc[1];
        run_cycles(1, 3'b111, 1'b1);
        run_cycles(5, 3'b111, 1'b0);
        chk("bp_one_more", 0, 128'(obs_acc[0] - a0), 128'(1));
        chk("bp_one_more", 1, 128'(obs_acc[1] - a2), 128'(1));
        run_cycles(12, 3'b000, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(3'($urandom), 27'($urandom), 27'($urandom),
                           ($urandom_range(0, 3) != 0));
        end
        run_cycles(12, 3'b000, 1'b1);

        $display("[TB] reset with work in flight");
        run_cycles(3, 3'b111, 1'b0);
        reset_dut();
        vv = 3'b111;
        #1;
        chk("post_reset_grant", 0, 128'(if0.req_ready), 128'(3'b001));
        chk("post_reset_grant", 1, 128'(if2.req_ready), 128'(3'b001));
        run_cycles(1, 3'b111, 1'b1);
        run_cycles(10, 3'b000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
